rings_anim_sched: RTL and testbench
===================================

Name: rings_anim_sched

Overview:
- Per-frame animation scheduler for the rings renderer.
- Holds the radius and colour state of every ring.
- On each vertical-blank pulse, steps each ring's radius, wrapping and advancing colour, and pushes one update per ring to the renderer's parameter registers over a valid/ready port.
- Also arbitrates host configuration writes (decoded from ui_in/uio_in by the top level) onto the same update port.

Parameters:
- NUM_RINGS, 4: number of rings; power of two; ring index width RW = $clog2(NUM_RINGS).
- RADIUS_W, 8: radius width.
- COLOR_W, 6: colour index width.
- MIN_RADIUS, 8: smallest radius.
- MAX_RADIUS, 200: largest radius; must satisfy MIN_RADIUS < MAX_RADIUS < 2^RADIUS_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse at start of vblank
- pause  in  1  freeze animation
- speed  in  3  radius step per frame, 0..7
- cfg_valid  in  1  host write request
- cfg_ready  out  1  host write accepted
- cfg_ring  in  RW  target ring
- cfg_radius  in  RADIUS_W  new radius
- cfg_color  in  COLOR_W  new colour
- upd_valid  out  1  update to renderer valid
- upd_ready  in  1  renderer accepts update
- upd_ring  out  RW  ring index of update
- upd_radius  out  RADIUS_W  radius of update
- upd_color  out  COLOR_W  colour of update
- busy  out  1  state != IDLE
- frame_count  out  8  accepted frames, wraps 255->0
- overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE.
  - radius[i] = MIN_RADIUS + i*((MAX_RADIUS-MIN_RADIUS)/NUM_RINGS); defaults 8, 56, 104, 152.
  - color[i] = i*(2^COLOR_W/NUM_RINGS); defaults 0, 16, 32, 48.
  - upd_valid/ring/radius/color = 0, frame_count = 0, overrun = 0, busy = 0.
  - Reset mid-operation aborts any transaction. upd_valid is 0 in the cycle after reset with no handshake completed.
- cfg_ready is combinational: (state==IDLE) & ~frame_start. frame_start has priority over host writes.
- FSM states:
  - IDLE:
    - If frame_start: frame_count += 1.
    - If frame_start & ~pause: go to SWEEP with idx = 0.
    - If frame_start & pause: stay in IDLE; no updates are issued.
    - Else if cfg_valid: clamp cfg_radius into [MIN_RADIUS, MAX_RADIUS], write radius/color[cfg_ring], go to CFG.
  - SWEEP:
    - Registered upd_* carry ring idx's next value; upd_valid = 1.
    - Outputs hold stable while upd_valid & ~upd_ready.
    - On handshake: commit the next value to radius/color[idx].
    - If idx == NUM_RINGS-1, go to IDLE; else idx += 1 and load the next ring's values in the same edge (back-to-back, no bubble).
  - CFG:
    - upd_* carry the written ring's committed value; upd_valid = 1.
    - On handshake, go to IDLE.
- Latency:
  - frame_start at edge T gives upd_valid at T+1 with ring 0.
  - With upd_ready tied 1, rings 0..3 are presented at T+1..T+4 and state is IDLE at T+5.
- Speed is sampled once at frame_start and used for the whole sweep.
- Radius step: s = r + speed, computed at RADIUS_W+1 bits.
  - If s > MAX_RADIUS: next = MIN_RADIUS + (s - MAX_RADIUS - 1), and color += 1 mod 2^COLOR_W.
  - Else next = s and color is unchanged.
  - speed = 0: the sweep still runs and values are unchanged.
- frame_start while busy: ignored, overrun = 1 (sticky until rst), frame_count unchanged.

Optional Feature:
- Macro: RINGS_REVERSE_EN.
- Defined:
  - Adds port dir (in, 1), sampled at frame_start.
  - dir = 1 computes d = r - speed, signed.
  - If d < MIN_RADIUS: next = MAX_RADIUS - (MIN_RADIUS - d - 1), and color -= 1 mod 2^COLOR_W.
  - dir = 0 behaves as without the macro.
- Undefined: the dir port is absent and radii only grow.

Test Plan:
1. Reset, then speed=2, upd_ready=1, one frame_start -> ring0..3 updates on T+1..T+4:
   - radii 10, 58, 106, 154; colours 0, 16, 32, 48.
   - busy low at T+5; frame_count = 1.
2. Host write ring2 radius=199 colour=63 -> CFG update (2, 199, 63). Then frame with speed=3 -> ring2 radius 9, colour 0.
   - Also: a write of radius 250 -> clamped to 200; a write of radius 3 -> clamped to 8.
3. Backpressure: upd_ready low for 3 cycles while ring1 is presented -> upd_* stable, ring1 state uncommitted, then ring2 follows on the cycle after ready rises.
4. Arbitration and overrun:
   - cfg_valid and frame_start in the same IDLE cycle -> cfg_ready = 0 and the sweep runs first.
   - frame_start during SWEEP -> overrun = 1, frame_count unchanged, sweep unaffected.
5. pause = 1 with frame_start -> no upd_valid, frame_count increments, radii unchanged.
6. rst asserted while ring2 is presented -> next cycle upd_valid = 0, radii back to 8, 56, 104, 152, overrun = 0. With RINGS_REVERSE_EN and dir = 1, speed = 5, ring0 at 8 -> radius 196, colour 63.

Source files
------------

// File: rtl/rings_anim_sched.sv
// rings_anim_sched: per-frame ring radius/colour animation scheduler with host config writes.
// Optional feature macro: RINGS_REVERSE_EN (adds dir input so radii can shrink).
module rings_anim_sched #(
  parameter int unsigned NUM_RINGS  = 4,
  parameter int unsigned RADIUS_W   = 8,
  parameter int unsigned COLOR_W    = 6,
  parameter int unsigned MIN_RADIUS = 8,
  parameter int unsigned MAX_RADIUS = 200,
  localparam int unsigned RW        = $clog2(NUM_RINGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                pause,
  input  logic [2:0]          speed,
`ifdef RINGS_REVERSE_EN
  input  logic                dir,
`endif
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [RW-1:0]       cfg_ring,
  input  logic [RADIUS_W-1:0] cfg_radius,
  input  logic [COLOR_W-1:0]  cfg_color,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [RW-1:0]       upd_ring,
  output logic [RADIUS_W-1:0] upd_radius,
  output logic [COLOR_W-1:0]  upd_color,
  output logic                busy,
  output logic [7:0]          frame_count,
  output logic                overrun
);

  localparam int unsigned SW          = RADIUS_W + 2;
  localparam int unsigned RADIUS_STEP = (MAX_RADIUS - MIN_RADIUS) / NUM_RINGS;
  localparam int unsigned COLOR_STEP  = (1 << COLOR_W) / NUM_RINGS;
  localparam int unsigned WRAP_SPAN   = MAX_RADIUS + 1 - MIN_RADIUS;
  localparam logic [RADIUS_W-1:0] MIN_R = RADIUS_W'(MIN_RADIUS);
  localparam logic [RADIUS_W-1:0] MAX_R = RADIUS_W'(MAX_RADIUS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CFG   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       idx_q, idx_d;
  logic [2:0]          speed_q, speed_d;
  logic [RADIUS_W-1:0] radius_q [NUM_RINGS];
  logic [RADIUS_W-1:0] radius_d [NUM_RINGS];
  logic [COLOR_W-1:0]  color_q  [NUM_RINGS];
  logic [COLOR_W-1:0]  color_d  [NUM_RINGS];

  logic                upd_valid_d;
  logic [RW-1:0]       upd_ring_d;
  logic [RADIUS_W-1:0] upd_radius_d;
  logic [COLOR_W-1:0]  upd_color_d;
  logic [7:0]          frame_count_d;
  logic                overrun_d;

  logic [RW-1:0]       step_ring;
  logic [2:0]          step_speed;
  logic [SW-1:0]       step_sum;
  logic [RADIUS_W-1:0] nxt_radius;
  logic [COLOR_W-1:0]  nxt_color;
  logic [RADIUS_W-1:0] cfg_clamped;

`ifdef RINGS_REVERSE_EN
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_RADIUS);
  logic                dir_q, dir_d;
  logic                step_dir;
  logic signed [SW-1:0] step_diff;
`endif

  // Host writes may only be taken in IDLE, and lose to a same-cycle frame_start.
  assign cfg_ready = (state_q == IDLE) & ~frame_start;

  // Next animated value for the ring about to be presented: ring 0 from IDLE, idx+1 mid-sweep.
  always_comb begin : step_calc
    step_ring  = (state_q == IDLE) ? '0 : RW'(idx_q + RW'(1));
    step_speed = (state_q == IDLE) ? speed : speed_q;
    step_sum   = SW'(radius_q[step_ring]) + SW'(step_speed);
    nxt_radius = RADIUS_W'(step_sum);
    nxt_color  = color_q[step_ring];
    if (step_sum > SW'(MAX_RADIUS)) begin
      nxt_radius = RADIUS_W'(step_sum - SW'(WRAP_SPAN));
      nxt_color  = color_q[step_ring] + COLOR_W'(1);
    end
`ifdef RINGS_REVERSE_EN
    step_dir  = (state_q == IDLE) ? dir : dir_q;
    step_diff = SW'(radius_q[step_ring]) - SW'(step_speed);
    if (step_dir) begin
      nxt_radius = RADIUS_W'(step_diff);
      nxt_color  = color_q[step_ring];
      if (step_diff < MIN_S) begin
        nxt_radius = RADIUS_W'(step_diff + SW'(WRAP_SPAN));
        nxt_color  = color_q[step_ring] - COLOR_W'(1);
      end
    end
`endif
  end

  always_comb begin : cfg_clamp
    cfg_clamped = cfg_radius;
    if (cfg_radius < MIN_R) cfg_clamped = MIN_R;
    else if (cfg_radius > MAX_R) cfg_clamped = MAX_R;
  end

  always_comb begin : fsm_next
    state_d       = state_q;
    idx_d         = idx_q;
    speed_d       = speed_q;
    radius_d      = radius_q;
    color_d       = color_q;
    upd_valid_d   = upd_valid;
    upd_ring_d    = upd_ring;
    upd_radius_d  = upd_radius;
    upd_color_d   = upd_color;
    frame_count_d = frame_count;
    overrun_d     = overrun;
`ifdef RINGS_REVERSE_EN
    dir_d         = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          frame_count_d = frame_count + 8'd1;
          if (!pause) begin
            state_d      = SWEEP;
            idx_d        = '0;
            speed_d      = speed;
`ifdef RINGS_REVERSE_EN
            dir_d        = dir;
`endif
            upd_valid_d  = 1'b1;
            upd_ring_d   = '0;
            upd_radius_d = nxt_radius;
            upd_color_d  = nxt_color;
          end
        end else if (cfg_valid) begin
          state_d            = CFG;
          radius_d[cfg_ring] = cfg_clamped;
          color_d[cfg_ring]  = cfg_color;
          upd_valid_d        = 1'b1;
          upd_ring_d         = cfg_ring;
          upd_radius_d       = cfg_clamped;
          upd_color_d        = cfg_color;
        end
      end
      SWEEP: begin
        if (frame_start) overrun_d = 1'b1;
        if (upd_ready) begin
          // Commit on handshake; the following ring is loaded in the same edge.
          radius_d[idx_q] = upd_radius;
          color_d[idx_q]  = upd_color;
          if (idx_q == RW'(NUM_RINGS - 1)) begin
            state_d     = IDLE;
            upd_valid_d = 1'b0;
          end else begin
            idx_d        = step_ring;
            upd_ring_d   = step_ring;
            upd_radius_d = nxt_radius;
            upd_color_d  = nxt_color;
          end
        end
      end
      CFG: begin
        if (frame_start) overrun_d = 1'b1;
        if (upd_ready) begin
          state_d     = IDLE;
          upd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        upd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      speed_q     <= '0;
      for (int unsigned i = 0; i < NUM_RINGS; i++) begin
        radius_q[i] <= RADIUS_W'(MIN_RADIUS + i * RADIUS_STEP);
        color_q[i]  <= COLOR_W'(i * COLOR_STEP);
      end
      upd_valid   <= 1'b0;
      upd_ring    <= '0;
      upd_radius  <= '0;
      upd_color   <= '0;
      busy        <= 1'b0;
      frame_count <= 8'd0;
      overrun     <= 1'b0;
`ifdef RINGS_REVERSE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      speed_q     <= speed_d;
      radius_q    <= radius_d;
      color_q     <= color_d;
      upd_valid   <= upd_valid_d;
      upd_ring    <= upd_ring_d;
      upd_radius  <= upd_radius_d;
      upd_color   <= upd_color_d;
      busy        <= (state_d != IDLE);
      frame_count <= frame_count_d;
      overrun     <= overrun_d;
`ifdef RINGS_REVERSE_EN
      dir_q       <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_rings_anim_sched.sv
// Testbench for rings_anim_sched: directed table vectors plus randomized traffic vs. a queue model.
module tb_rings_anim_sched;

  localparam int NR   = 4;
  localparam int MINR = 8;
  localparam int MAXR = 200;
  localparam int NCOL = 64;

  typedef struct {
    int ring;
    int radius;
    int color;
  } upd_t;

  typedef struct {
    int ring;
    int radius_in;
    int color_in;
    int exp_radius;
  } cfg_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       pause;
  logic [2:0] speed;
  logic       dir;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ring;
  logic [7:0] cfg_radius;
  logic [5:0] cfg_color;
  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] upd_ring;
  logic [7:0] upd_radius;
  logic [5:0] upd_color;
  logic       busy;
  logic [7:0] frame_count;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;

  rings_anim_sched dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pause(pause), .speed(speed),
`ifdef RINGS_REVERSE_EN
    .dir(dir),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ring(cfg_ring),
    .cfg_radius(cfg_radius), .cfg_color(cfg_color),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_ring(upd_ring),
    .upd_radius(upd_radius), .upd_color(upd_color),
    .busy(busy), .frame_count(frame_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_upd(input string name, input int ring, input int radius, input int color);
    check({name, "_valid"}, int'(upd_valid), 1);
    check({name, "_ring"}, int'(upd_ring), ring);
    check({name, "_radius"}, int'(upd_radius), radius);
    check({name, "_color"}, int'(upd_color), color);
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_start = 1'b0; pause = 1'b0; speed = 3'd0; dir = 1'b0;
    cfg_valid = 1'b0; cfg_ring = 2'd0; cfg_radius = 8'd0; cfg_color = 6'd0; upd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: one frame step of a ring from the radius/colour rules.
  function automatic void model_step(input int r, input int c, input int spd, input int d,
                                     output int nr, output int nc);
    nr = r; nc = c;
    if (d == 0) begin
      if (r + spd > MAXR) begin nr = MINR + (r + spd - MAXR - 1); nc = (c + 1) % NCOL; end
      else nr = r + spd;
    end else begin
      if (r - spd < MINR) begin nr = MAXR - (MINR - (r - spd) - 1); nc = (c + NCOL - 1) % NCOL; end
      else nr = r - spd;
    end
  endfunction

  upd_t     t1_exp [NR];
  cfg_vec_t cfg_tab [5];
  int       m_rad [NR];
  int       m_col [NR];
  int       m_fc;
  int       m_ovr;
  upd_t     exp_q [$];
  upd_t     e;
  int       nr, nc, cr;
  bit       idle;

  initial begin
    t1_exp[0] = '{0, 10, 0};
    t1_exp[1] = '{1, 58, 16};
    t1_exp[2] = '{2, 106, 32};
    t1_exp[3] = '{3, 154, 48};
    cfg_tab[0] = '{0, 250, 5, 200};
    cfg_tab[1] = '{1, 3, 7, 8};
    cfg_tab[2] = '{3, 200, 1, 200};
    cfg_tab[3] = '{2, 8, 2, 8};
    cfg_tab[4] = '{1, 100, 9, 100};

    // Reset state and a basic speed-2 sweep
    do_reset();
    check("rst_upd_valid", int'(upd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_upd_radius", int'(upd_radius), 0);
    speed = 3'd2; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      check_upd("sweep1", t1_exp[i].ring, t1_exp[i].radius, t1_exp[i].color);
      tick();
    end
    check("sweep1_busy_end", int'(busy), 0);
    check("sweep1_valid_end", int'(upd_valid), 0);
    check("sweep1_frame_count", int'(frame_count), 1);

    // Host write then wrap of the written ring
    cfg_valid = 1'b1; cfg_ring = 2'd2; cfg_radius = 8'd199; cfg_color = 6'd63;
    #1 check("cfg_ready_idle", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    check_upd("cfg_write", 2, 199, 63);
    check("cfg_busy", int'(busy), 1);
    tick();
    check("cfg_done_busy", int'(busy), 0);
    speed = 3'd3; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    check_upd("wrap_ring2", 2, 9, 0);
    tick();
    tick();
    check("wrap_busy_end", int'(busy), 0);

    // Clamp table
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_ring = 2'(cfg_tab[i].ring);
      cfg_radius = 8'(cfg_tab[i].radius_in); cfg_color = 6'(cfg_tab[i].color_in);
      #1 check("clamp_cfg_ready", int'(cfg_ready), 1);
      tick();
      cfg_valid = 1'b0;
      check_upd("clamp", cfg_tab[i].ring, cfg_tab[i].exp_radius, cfg_tab[i].color_in);
      tick();
      check("clamp_idle", int'(busy), 0);
    end

    // Backpressure on ring 1
    do_reset();
    speed = 3'd1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_upd("bp_ring0", 0, 9, 0);
    tick();
    check_upd("bp_ring1", 1, 57, 16);
    upd_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_upd("bp_hold", 1, 57, 16);
    end
    upd_ready = 1'b1;
    tick();
    check_upd("bp_ring2", 2, 105, 32);
    tick();
    check_upd("bp_ring3", 3, 153, 48);
    tick();
    check("bp_idle", int'(busy), 0);
    speed = 3'd0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check_upd("bp_commit_once", 1, 57, 16);
    tick(); tick(); tick();

    // Arbitration and overrun
    do_reset();
    cfg_valid = 1'b1; cfg_ring = 2'd1; cfg_radius = 8'd77; cfg_color = 6'd3;
    frame_start = 1'b1; speed = 3'd0;
    #1 check("arb_cfg_ready", int'(cfg_ready), 0);
    tick();
    frame_start = 1'b0;
    check_upd("arb_ring0", 0, 8, 0);
    frame_start = 1'b1;
    #1 check("arb_cfg_ready_sweep", int'(cfg_ready), 0);
    tick();
    frame_start = 1'b0;
    check_upd("ovr_ring1", 1, 56, 16);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_frame_count", int'(frame_count), 1);
    tick();
    check_upd("ovr_ring2", 2, 104, 32);
    tick();
    check_upd("ovr_ring3", 3, 152, 48);
    tick();
    check("arb_idle", int'(busy), 0);
    check("arb_cfg_ready_after", int'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    check_upd("arb_cfg", 1, 77, 3);
    tick();
    check("arb_end_busy", int'(busy), 0);
    check("arb_end_overrun", int'(overrun), 1);

    // Pause
    do_reset();
    pause = 1'b1; speed = 3'd4; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; pause = 1'b0;
    check("pause_valid", int'(upd_valid), 0);
    check("pause_busy", int'(busy), 0);
    check("pause_frame_count", int'(frame_count), 1);
    tick();
    check("pause_valid2", int'(upd_valid), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_upd("pause_after", 0, 12, 0);
    check("pause_frame_count2", int'(frame_count), 2);
    tick(); tick(); tick(); tick();
    check("pause_end_busy", int'(busy), 0);

    // Reset mid-sweep
    do_reset();
    speed = 3'd1; frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    tick();
    check_upd("midrst_ring2", 2, 105, 32);
    check("midrst_overrun", int'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", int'(upd_valid), 0);
    check("midrst_overrun_clr", int'(overrun), 0);
    check("midrst_frame_count", int'(frame_count), 0);
    check("midrst_busy", int'(busy), 0);
    speed = 3'd0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      check_upd("midrst_default", i, MINR + i * 48, i * 16);
      tick();
    end
`ifdef RINGS_REVERSE_EN
    do_reset();
    dir = 1'b1; speed = 3'd5; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; dir = 1'b0;
    check_upd("rev_ring0", 0, 196, 63);
    tick(); tick(); tick(); tick();
`endif

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < NR; i++) begin m_rad[i] = MINR + i * 48; m_col[i] = i * 16; end
    m_fc = 0; m_ovr = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle = (exp_q.size() == 0);
      check("rnd_valid", int'(upd_valid), idle ? 0 : 1);
      check("rnd_busy", int'(busy), idle ? 0 : 1);
      check("rnd_frame_count", int'(frame_count), m_fc);
      check("rnd_overrun", int'(overrun), m_ovr);
      frame_start = ($urandom_range(0, 11) == 0);
      pause       = ($urandom_range(0, 7) == 0);
      speed       = 3'($urandom_range(0, 7));
`ifdef RINGS_REVERSE_EN
      dir         = 1'($urandom_range(0, 1));
`endif
      cfg_valid   = ($urandom_range(0, 4) == 0);
      cfg_ring    = 2'($urandom_range(0, 3));
      cfg_radius  = 8'($urandom_range(0, 255));
      cfg_color   = 6'($urandom_range(0, 63));
      upd_ready   = ($urandom_range(0, 3) != 0);
      #1 check("rnd_cfg_ready", int'(cfg_ready), (idle && !frame_start) ? 1 : 0);
      if (upd_valid && upd_ready) begin
        if (exp_q.size() == 0) check("rnd_unexpected_upd", int'(upd_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("rnd_upd_ring", int'(upd_ring), e.ring);
          check("rnd_upd_radius", int'(upd_radius), e.radius);
          check("rnd_upd_color", int'(upd_color), e.color);
        end
      end
      if (frame_start) begin
        if (idle) begin
          m_fc = (m_fc + 1) % 256;
          if (!pause) begin
            for (int i = 0; i < NR; i++) begin
              model_step(m_rad[i], m_col[i], int'(speed), int'(dir), nr, nc);
              m_rad[i] = nr; m_col[i] = nc;
              exp_q.push_back('{i, nr, nc});
            end
          end
        end else m_ovr = 1;
      end else if (cfg_valid && idle) begin
        cr = int'(cfg_radius);
        if (cr < MINR) cr = MINR;
        if (cr > MAXR) cr = MAXR;
        m_rad[cfg_ring] = cr; m_col[cfg_ring] = int'(cfg_color);
        exp_q.push_back('{int'(cfg_ring), cr, int'(cfg_color)});
      end
      tick();
    end
    frame_start = 1'b0; cfg_valid = 1'b0; upd_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      if (upd_valid) begin
        e = exp_q.pop_front();
        check("drain_upd_ring", int'(upd_ring), e.ring);
        check("drain_upd_radius", int'(upd_radius), e.radius);
        check("drain_upd_color", int'(upd_color), e.color);
      end
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid", int'(upd_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
